// File: rtl/wb_gpio_pkg.sv
// Shared register offsets and byte-lane helper for the Wishbone GPIO block.
package wb_gpio_pkg;

  // Word offsets, decoded from wb_adr_i[4:2]
  localparam logic [2:0] GPIO_IN   = 3'd0;
  localparam logic [2:0] GPIO_OUT  = 3'd1;
  localparam logic [2:0] GPIO_RISE = 3'd2;
  localparam logic [2:0] GPIO_FALL = 3'd3;
  localparam logic [2:0] GPIO_IP   = 3'd4;

  function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_gpio_debounce.sv
// Two-flop synchronizer plus tick-sampled debounce; a bit must match on two ticks.
module gpio_debounce #(
  parameter int width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] sync1;
  logic [width-1:0] sync2;
  logic [width-1:0] prev;
  logic [width-1:0] agree;

  assign agree = ~(sync2 ^ prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      dout  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (tick) begin
        prev <= sync2;
        dout <= (sync2 & agree) | (dout & ~agree);
      end
    end
  end

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO slave: debounced inputs, registered outputs, per-bit edge interrupts.
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int unsigned clk_freq    = 50000000,
  parameter int unsigned debounce_us = 1000,
  parameter int          in_width    = 12,
  parameter int          out_width   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  input  logic [in_width-1:0]  gpio_i,
  output logic [out_width-1:0] gpio_o,
  output logic                 intr
);

  localparam int unsigned PRESCALE_RAW = (clk_freq / 32'd1000000) * debounce_us;
  localparam int unsigned PRESCALE     = (PRESCALE_RAW == 0) ? 1 : PRESCALE_RAW;

  logic [31:0]          pre_cnt;
  logic                 tick;
  logic [in_width-1:0]  stable;
  logic [in_width-1:0]  stable_d;
  logic [in_width-1:0]  rise_en;
  logic [in_width-1:0]  fall_en;
  logic [in_width-1:0]  ip;
  logic [in_width-1:0]  edge_set;
  logic [in_width-1:0]  ip_clr;
  logic [out_width-1:0] out_q;
  logic                 acc;
  logic                 wr;
  logic [2:0]           reg_sel;
  logic [31:0]          rd_data;
  logic [31:0]          w_out;
  logic [31:0]          w_rise;
  logic [31:0]          w_fall;
  logic [31:0]          w_clr;
  logic                 unused_ok;

  assign tick = (pre_cnt == PRESCALE - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 32'd1;
  end

  gpio_debounce #(.width(in_width)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .din   (gpio_i),
    .dout  (stable)
  );

  // A new access is accepted only while ack is low, so acks never run back-to-back
  assign acc     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr      = acc & wb_we_i;
  assign reg_sel = wb_adr_i[4:2];

  assign w_out  = apply_sel(32'(out_q),   wb_dat_i, wb_sel_i);
  assign w_rise = apply_sel(32'(rise_en), wb_dat_i, wb_sel_i);
  assign w_fall = apply_sel(32'(fall_en), wb_dat_i, wb_sel_i);
  assign w_clr  = apply_sel(32'd0,        wb_dat_i, wb_sel_i);

  assign edge_set = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
  assign ip_clr   = (wr && reg_sel == GPIO_IP) ? w_clr[in_width-1:0] : '0;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      GPIO_IN:   rd_data = 32'(stable);
      GPIO_OUT:  rd_data = 32'(out_q);
      GPIO_RISE: rd_data = 32'(rise_en);
      GPIO_FALL: rd_data = 32'(fall_en);
      GPIO_IP:   rd_data = 32'(ip);
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      out_q    <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      ip       <= '0;
      stable_d <= '0;
      intr     <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rd_data : '0;
      if (wr && reg_sel == GPIO_OUT)  out_q   <= w_out[out_width-1:0];
      if (wr && reg_sel == GPIO_RISE) rise_en <= w_rise[in_width-1:0];
      if (wr && reg_sel == GPIO_FALL) fall_en <= w_fall[in_width-1:0];
      // A fresh edge on the same bit as a W1C keeps the flag set
      ip       <= (ip & ~ip_clr) | edge_set;
      stable_d <= stable;
      intr     <= |ip;
    end
  end

  assign gpio_o = out_q;

  assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], w_out, w_rise, w_fall, w_clr};

endmodule

// File: tb/tb_wb_gpio.sv
// Directed bench for wb_gpio with a short debounce period (8 clocks per tick).
module tb_wb_gpio;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic [11:0] gpio_i;
  logic [7:0]  gpio_o;
  logic        intr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  // Posedges since reset release; the DUT prescaler ticks on every 8th
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  wb_gpio #(
    .clk_freq    (1000000),
    .debounce_us (8),
    .in_width    (12),
    .out_width   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_ack_o (wb_ack_o),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .intr     (intr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    check_eq("wr_ack_idle", 32'(wb_ack_o), 32'd0);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check_eq("wr_ack", 32'(wb_ack_o), 32'd1);
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    @(negedge clk);
    check_eq("rd_ack_idle", 32'(wb_ack_o), 32'd0);
    wb_adr_i = adr; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check_eq("rd_ack", 32'(wb_ack_o), 32'd1);
    dat = wb_dat_o;
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          c0;
    int          m;
    logic        found;

    reset = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    gpio_i = 12'h0A5;
    repeat (3) @(negedge clk);
    check_eq("rst_gpio_o", 32'(gpio_o), 32'd0);
    check_eq("rst_intr", 32'(intr), 32'd0);
    check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
    check_eq("rst_dat", wb_dat_o, 32'd0);
    reset = 1'b0;

    // Debounced input lags until the value agrees on two ticks
    wb_read(32'h00, rd); check_eq("in_early", rd, 32'h000);
    repeat (26) @(negedge clk);
    wb_read(32'h00, rd); check_eq("in_settled", rd, 32'h0A5);
    wb_read(32'h10, rd); check_eq("ip_none", rd, 32'h000);
    gpio_i = 12'h0A4;
    repeat (26) @(negedge clk);
    wb_read(32'h00, rd); check_eq("in_bit0_low", rd, 32'h0A4);

    // OUT write through lane 0, lane 1 lies above out_width
    wb_write(32'h04, 32'h0000_003C, 4'b0001);
    check_eq("gpio_o_write", 32'(gpio_o), 32'h3C);
    wb_write(32'h04, 32'h0000_5500, 4'b0010);
    check_eq("gpio_o_sel", 32'(gpio_o), 32'h3C);
    // Hold stb for two edges: one ack, then a gap
    @(negedge clk);
    wb_adr_i = 32'h04; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check_eq("hold_ack1", 32'(wb_ack_o), 32'd1);
    check_eq("out_readback", wb_dat_o, 32'h3C);
    @(posedge clk); #1;
    check_eq("hold_ack2", 32'(wb_ack_o), 32'd0);
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;

    // Short glitch on bit 0 with rising edges enabled
    wb_write(32'h08, 32'h001, 4'hF);
    wb_read(32'h08, rd); check_eq("rise_rb", rd, 32'h001);
    gpio_i = 12'h0A5;
    repeat (3) @(negedge clk);
    gpio_i = 12'h0A4;
    repeat (26) @(negedge clk);
    wb_read(32'h00, rd); check_eq("glitch_in", rd, 32'h0A4);
    wb_read(32'h10, rd); check_eq("glitch_ip", rd, 32'h000);
    check_eq("glitch_intr", 32'(intr), 32'd0);

    // Real rising edge, then an unenabled falling edge
    gpio_i = 12'h0A5;
    repeat (26) @(negedge clk);
    wb_read(32'h10, rd); check_eq("rise_ip", rd, 32'h001);
    check_eq("rise_intr", 32'(intr), 32'd1);
    gpio_i = 12'h0A4;
    repeat (26) @(negedge clk);
    wb_read(32'h00, rd); check_eq("fall_in", rd, 32'h0A4);
    wb_read(32'h10, rd); check_eq("fall_ip", rd, 32'h001);

    // W1C landing on the same edge that sets bit 0
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      if (cyc % 8 == 1) found = 1'b1;
    end
    check_eq("align_tick", 32'(found), 32'd1);
    c0 = cyc;
    gpio_i = 12'h0A5;
    m = c0 + 15;
    found = 1'b0;
    for (int k = 0; k < 32 && !found; k++) begin
      @(negedge clk);
      if (cyc == m - 1) found = 1'b1;
    end
    check_eq("align_edge", 32'(found), 32'd1);
    wb_write(32'h10, 32'h001, 4'b0001);
    wb_read(32'h10, rd); check_eq("w1c_race_ip", rd, 32'h001);
    check_eq("w1c_race_intr", 32'(intr), 32'd1);
    wb_read(32'h00, rd); check_eq("race_in", rd, 32'h0A5);

    // Disabling RISE keeps the pending flag; zero bits in a W1C are ignored
    wb_write(32'h08, 32'h000, 4'hF);
    wb_write(32'h10, 32'h000, 4'hF);
    wb_read(32'h10, rd); check_eq("ip_kept", rd, 32'h001);

    // Plain W1C: flag clears, intr follows one cycle later
    wb_write(32'h10, 32'h001, 4'b0001);
    check_eq("w1c_intr_lag", 32'(intr), 32'd1);
    @(posedge clk); #1;
    check_eq("w1c_intr", 32'(intr), 32'd0);
    wb_read(32'h10, rd); check_eq("w1c_ip", rd, 32'h000);

    // Reset arriving with a write strobe
    @(negedge clk);
    reset = 1'b1;
    wb_adr_i = 32'h04; wb_dat_i = 32'h77; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    #1;
    check_eq("rstw_ack", 32'(wb_ack_o), 32'd0);
    check_eq("rstw_gpio_o", 32'(gpio_o), 32'd0);
    @(posedge clk); #1;
    check_eq("rstw_ack_edge", 32'(wb_ack_o), 32'd0);
    check_eq("rstw_gpio_o_edge", 32'(gpio_o), 32'd0);
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    reset = 1'b0;
    wb_read(32'h04, rd); check_eq("rstw_out", rd, 32'h00);

    // Reserved offset: acked, reads zero, writes ignored
    wb_write(32'h18, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h18, rd); check_eq("rsvd_rd", rd, 32'h0);
    wb_read(32'h04, rd); check_eq("rsvd_out", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
